// File: rtl/input_sync_pkg.sv
// Shared constants and helpers for the input synchronizer / debounce block.
package input_sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;

  // The counter must be able to hold values up to DEBOUNCE_CYCLES without wrapping.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One input bit: flop synchronizer, saturating debounce counter, stable level
// and registered rise/fall strobes.
module sync_debounce_channel
  import input_sync_pkg::*;
#(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_level,
  output logic o_synced,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_stable;
  logic              r_rise;
  logic              r_fall;

  logic              w_synced;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_stable_nxt;

  // Synchronizer chain: bit 0 samples the asynchronous level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_level};
    end
  end

  assign w_synced = r_sync[STAGES-1];

  // Debounce: a mismatch must persist for DEBOUNCE_CYCLES consecutive cycles;
  // any return to the accepted level clears the count.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    if (w_synced == r_stable) begin
      w_cnt_nxt = '0;
    end else if (r_cnt >= CNT_LAST) begin
      w_stable_nxt = w_synced;
      w_cnt_nxt    = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Stable level and strobes update on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= w_stable_nxt & ~r_stable;
      r_fall   <= ~w_stable_nxt & r_stable;
    end
  end

  assign o_synced = w_synced;
  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/sync_debounce_inputs.sv
// Multi-channel conditioner for asynchronous board inputs: optional inversion,
// synchronization, debounce, and clean rise/fall event strobes per channel.
module sync_debounce_inputs
  import input_sync_pkg::*;
#(
  parameter int               WIDTH           = 5,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  if ((STAGES < MIN_STAGES) || (STAGES > MAX_STAGES)) begin : g_bad_stages
    $error("sync_debounce_inputs: STAGES must be within 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_debounce_inputs: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] w_level;

  // Active-low keys are flipped before the first synchronizer flop.
  assign w_level = async_in ^ INVERT_MASK;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    sync_debounce_channel #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_level  (w_level[g]),
      .o_synced (synced[g]),
      .o_stable (stable[g]),
      .o_rise   (rise[g]),
      .o_fall   (fall[g])
    );
  end

  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_sync_debounce_inputs.sv
// Directed bench for sync_debounce_inputs (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4).
module tb_sync_debounce_inputs;

  localparam int W = 4;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] async_in;
  logic [W-1:0] synced;
  logic [W-1:0] stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;

  int n_chk;
  int n_fail;
  int n_any;

  sync_debounce_inputs #(
    .WIDTH           (W),
    .STAGES          (2),
    .DEBOUNCE_CYCLES (4),
    .INVERT_MASK     (4'b0001)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .async_in   (async_in),
    .synced     (synced),
    .stable     (stable),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    async_in = 4'b0001;

    // 1. reset held with ch0 idle-high (logical 0)
    repeat (3) tick();
    chk("rst_hold", {synced, stable, rise, fall, any_change}, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("rst_idle_%0d", k), {synced, stable, rise, fall, any_change}, 0);
    end

    // 2. clean press on ch1
    async_in = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("press_sync_%0d", k), synced[1], (k >= 2));
      chk($sformatf("press_stab_%0d", k), stable[1], (k >= 6));
      chk($sformatf("press_rise_%0d", k), rise, (k == 6) ? 4'b0010 : 4'b0000);
      chk($sformatf("press_any_%0d", k), any_change, (k == 6));
    end

    // 3. bounce on ch2, then settle high
    for (int p = 0; p < 4; p++) begin
      async_in[2] = (p % 2 == 0);
      repeat (2) begin
        tick();
        chk($sformatf("bounce_quiet_p%0d", p), {rise[2], fall[2], stable[2]}, 0);
      end
    end
    async_in[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("bounce_rise_%0d", k), rise, (k == 6) ? 4'b0100 : 4'b0000);
      chk($sformatf("bounce_fall_%0d", k), fall, 0);
    end

    // 4. inverted key on ch0: press (pin low) then release
    async_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("inv_press_rise_%0d", k), rise, (k == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("inv_press_fall_%0d", k), fall, 0);
    end
    chk("inv_press_stable", stable, 4'b0111);
    async_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("inv_rel_fall_%0d", k), fall, (k == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("inv_rel_rise_%0d", k), rise, 0);
    end
    chk("inv_rel_stable", stable, 4'b0110);

    // 5. simultaneous opposite changes: first move to ch1=0, ch3=1
    async_in = 4'b1101;
    repeat (10) tick();
    chk("simul_pre_stable", stable, 4'b1100);
    async_in = 4'b0111;
    n_any = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (any_change) n_any++;
      chk($sformatf("simul_rise_%0d", k), rise, (k == 6) ? 4'b0010 : 4'b0000);
      chk($sformatf("simul_fall_%0d", k), fall, (k == 6) ? 4'b1000 : 4'b0000);
    end
    chk("simul_any_count", n_any, 1);
    chk("simul_stable", stable, 4'b0110);

    // 6. reset in the middle of a pending change on ch1
    async_in = 4'b0101;
    repeat (10) tick();
    chk("midrst_pre_stable", stable, 4'b0100);
    async_in = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("midrst_count_rise_%0d", k), rise, 0);
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_async_clear", {synced, stable, rise, fall, any_change}, 0);
    repeat (2) tick();
    chk("midrst_held", {synced, stable, rise, fall, any_change}, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("midrst_rise_%0d", k), rise, (k == 6) ? 4'b0110 : 4'b0000);
      chk($sformatf("midrst_fall_%0d", k), fall, 0);
    end
    chk("midrst_stable", stable, 4'b0110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
